// File: rtl/rom_stream_loader.sv
// rom_stream_loader: assembles DATA_WIDTH words from a valid/ready byte stream
// and pushes them into hack_soc over the load/sck/data/ack handshake. The Hack
// CPU is held in reset until the requested number of words has been delivered.
module rom_stream_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] word_count,
    input  logic                   s_valid,
    input  logic [7:0]             s_data,
    output logic                   s_ready,
    output logic                   rom_loader_load,
    output logic                   rom_loader_sck,
    output logic [DATA_WIDTH-1:0]  rom_loader_data,
    input  logic                   rom_loader_ack,
    output logic                   hack_external_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] words_loaded
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TW  = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ASSEMBLE    = 3'd1,
        PRESENT     = 3'd2,
        WAIT_ACK_HI = 3'd3,
        WAIT_ACK_LO = 3'd4,
        DONE        = 3'd5,
        ERROR       = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] words_loaded_q, words_loaded_d;
    logic                   s_ready_q, s_ready_d;
    logic                   load_q, load_d;
    logic                   sck_q, sck_d;
    logic                   hack_reset_q, hack_reset_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    logic                   start_take;
    logic                   byte_take;
    logic                   last_byte;
    logic                   tmo_expired;
    logic [COUNT_WIDTH-1:0] wl_inc;

    // Place a new byte into the partial word according to the byte order.
    function automatic logic [DATA_WIDTH-1:0] shift_in(
        input logic [DATA_WIDTH-1:0] cur,
        input logic [7:0]            b
    );
        if (MSB_FIRST) begin
            shift_in = (cur << 8) | DATA_WIDTH'(b);
        end else begin
            shift_in = (cur >> 8) | (DATA_WIDTH'(b) << (DATA_WIDTH - 8));
        end
    endfunction

    assign start_take  = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
    assign byte_take   = s_valid && s_ready_q && (state_q == ASSEMBLE);
    assign last_byte   = (byte_cnt_q == BCW'(BPW - 1));
    assign tmo_expired = (tmo_q == TW'(ACK_TIMEOUT));
    assign wl_inc      = (words_loaded_q == count_q) ? words_loaded_q
                                                     : words_loaded_q + COUNT_WIDTH'(1);

    // Next-state decision for the load session.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = (word_count == {COUNT_WIDTH{1'b0}}) ? DONE : ASSEMBLE;
                end else begin
                    state_d = state_q;
                end
            end
            ASSEMBLE: begin
                if (byte_take && last_byte) begin
                    state_d = PRESENT;
                end else begin
                    state_d = ASSEMBLE;
                end
            end
            PRESENT: state_d = WAIT_ACK_HI;
            WAIT_ACK_HI: begin
                if (rom_loader_ack) begin
                    state_d = WAIT_ACK_LO;
                end else if (tmo_expired) begin
                    state_d = ERROR;
                end else begin
                    state_d = WAIT_ACK_HI;
                end
            end
            WAIT_ACK_LO: begin
                if (!rom_loader_ack) begin
                    state_d = (wl_inc == count_q) ? DONE : ASSEMBLE;
                end else if (tmo_expired) begin
                    state_d = ERROR;
                end else begin
                    state_d = WAIT_ACK_LO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs follow the state being entered; datapath and counters update alongside.
    always_comb begin
        s_ready_d      = (state_d == ASSEMBLE);
        load_d         = (state_d == ASSEMBLE) || (state_d == PRESENT) ||
                         (state_d == WAIT_ACK_HI) || (state_d == WAIT_ACK_LO);
        busy_d         = load_d;
        sck_d          = (state_d == WAIT_ACK_HI);
        done_d         = (state_d == DONE);
        error_d        = (state_d == ERROR);
        hack_reset_d   = (state_d != DONE);
        shift_d        = shift_q;
        byte_cnt_d     = byte_cnt_q;
        data_d         = data_q;
        count_d        = count_q;
        words_loaded_d = words_loaded_q;

        if (start_take) begin
            count_d        = word_count;
            words_loaded_d = {COUNT_WIDTH{1'b0}};
            byte_cnt_d     = {BCW{1'b0}};
            shift_d        = {DATA_WIDTH{1'b0}};
        end else if (byte_take) begin
            shift_d = shift_in(shift_q, s_data);
            if (last_byte) begin
                byte_cnt_d = {BCW{1'b0}};
                data_d     = shift_in(shift_q, s_data);
            end else begin
                byte_cnt_d = byte_cnt_q + BCW'(1);
            end
        end else if ((state_q == WAIT_ACK_LO) && !rom_loader_ack) begin
            words_loaded_d = wl_inc;
        end else begin
            words_loaded_d = words_loaded_q;
        end

        // The ack timer restarts whenever a wait state is entered.
        if (state_d != state_q) begin
            tmo_d = {TW{1'b0}};
        end else if ((state_q == WAIT_ACK_HI) || (state_q == WAIT_ACK_LO)) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = {TW{1'b0}};
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            byte_cnt_q     <= {BCW{1'b0}};
            shift_q        <= {DATA_WIDTH{1'b0}};
            data_q         <= {DATA_WIDTH{1'b0}};
            tmo_q          <= {TW{1'b0}};
            count_q        <= {COUNT_WIDTH{1'b0}};
            words_loaded_q <= {COUNT_WIDTH{1'b0}};
            s_ready_q      <= 1'b0;
            load_q         <= 1'b0;
            sck_q          <= 1'b0;
            hack_reset_q   <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            shift_q        <= shift_d;
            data_q         <= data_d;
            tmo_q          <= tmo_d;
            count_q        <= count_d;
            words_loaded_q <= words_loaded_d;
            s_ready_q      <= s_ready_d;
            load_q         <= load_d;
            sck_q          <= sck_d;
            hack_reset_q   <= hack_reset_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign s_ready             = s_ready_q;
    assign rom_loader_load     = load_q;
    assign rom_loader_sck      = sck_q;
    assign rom_loader_data     = data_q;
    assign hack_external_reset = hack_reset_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign error               = error_q;
    assign words_loaded        = words_loaded_q;

endmodule

// File: tb/tb_rom_stream_loader.sv
// Bench for rom_stream_loader: an MSB-first and an LSB-first instance share
// all stimulus and a soc ack model; delivered words are compared against words
// computed arithmetically from the byte list.
module tb_rom_stream_loader;

    localparam int DW      = 16;
    localparam int CW      = 16;
    localparam int BPW     = DW / 8;
    localparam int ACK_DLY = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] word_count;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          ack;
    logic          ack_stuck;

    logic          s_ready, load, sck, hack_rst, busy, done, error;
    logic [DW-1:0] data;
    logic [CW-1:0] words_loaded;
    logic          l_s_ready, l_load, l_sck, l_hack_rst, l_busy, l_done, l_error;
    logic [DW-1:0] l_data;
    logic [CW-1:0] l_words_loaded;

    logic [7:0]    bytes_q[$];
    logic [DW-1:0] got_m[$];
    logic [DW-1:0] got_l[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rom_stream_loader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .MSB_FIRST(1'b1), .ACK_TIMEOUT(15)) dut_m (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .rom_loader_load(load), .rom_loader_sck(sck), .rom_loader_data(data),
        .rom_loader_ack(ack), .hack_external_reset(hack_rst), .busy(busy),
        .done(done), .error(error), .words_loaded(words_loaded)
    );

    rom_stream_loader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .MSB_FIRST(1'b0), .ACK_TIMEOUT(15)) dut_l (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .s_valid(s_valid), .s_data(s_data), .s_ready(l_s_ready),
        .rom_loader_load(l_load), .rom_loader_sck(l_sck), .rom_loader_data(l_data),
        .rom_loader_ack(ack), .hack_external_reset(l_hack_rst), .busy(l_busy),
        .done(l_done), .error(l_error), .words_loaded(l_words_loaded)
    );

    // soc model: ack follows sck after ACK_DLY cycles; words captured at sck rise
    initial begin
        logic sck_prev;
        int   cnt;
        ack = 1'b0;
        sck_prev = 1'b0;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (sck && !sck_prev) begin
                got_m.push_back(data);
                got_l.push_back(l_data);
            end
            sck_prev = sck;
            if (ack_stuck) begin
                ack = 1'b0;
                cnt = 0;
            end else if (sck != ack) begin
                cnt++;
                if (cnt >= ACK_DLY) begin
                    ack = sck;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Expected word from the byte list: first byte most or least significant.
    function automatic logic [DW-1:0] ref_word(input int idx, input bit msb);
        int w;
        int b;
        w = 0;
        for (int k = 0; k < BPW; k++) begin
            b = int'(bytes_q[idx*BPW + k]);
            if (msb) w = w * 256 + b;
            else     w = w + b * (1 << (8 * k));
        end
        return w[DW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_session(input int n);
        got_m.delete();
        got_l.delete();
        start = 1'b1;
        word_count = CW'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        int   k;
        s_valid = 1'b1;
        s_data  = b;
        k = 0;
        rdy = 1'b0;
        while (!rdy && k < 200) begin
            rdy = s_ready;
            tick();
            k++;
        end
        s_valid = 1'b0;
        if (!rdy) begin
            n_vec++; n_err++;
            $display("FAIL byte_accept_timeout byte=%h not accepted within 200 cycles", b);
        end
    endtask

    task automatic feed_range(input int first, input int last, input int gap_max);
        for (int i = first; i <= last; i++) begin
            repeat ($urandom_range(gap_max, 0)) tick();
            send_byte(bytes_q[i]);
        end
    endtask

    task automatic wait_end(input int budget);
        int k;
        k = 0;
        while (!done && !error && k < budget) begin
            tick();
            k++;
        end
        if (!done && !error) begin
            n_vec++; n_err++;
            $display("FAIL session_end_timeout no done/error within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_vec++;
        if ({s_ready, load, sck, busy, done, error, hack_rst} !== 7'b0000001) begin
            n_err++;
            $display("FAIL reset_ctrl got %b want 0000001", {s_ready, load, sck, busy, done, error, hack_rst});
        end
        n_vec++;
        if (data !== 16'h0000 || words_loaded !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_data got data=%h wl=%0d want 0/0", data, words_loaded);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_zero_count();
        logic seen;
        start_session(0);
        n_vec++;
        if (done !== 1'b1 || words_loaded !== 16'd0 || hack_rst !== 1'b0) begin
            n_err++;
            $display("FAIL zero_count got done=%b wl=%0d hrst=%b want 1/0/0", done, words_loaded, hack_rst);
        end
        seen = load | sck;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | load | sck;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL zero_count_strobes got load/sck seen=%b want 0", seen);
        end
    endtask

    task automatic run_checked(input string name, input int n, input int gap_max);
        start_session(n);
        n_vec++;
        if ({load, busy, s_ready, hack_rst, done, error} !== 6'b111100) begin
            n_err++;
            $display("FAIL %s_start got %b want 111100", name, {load, busy, s_ready, hack_rst, done, error});
        end
        feed_range(0, n*BPW - 1, gap_max);
        wait_end(400);
        n_vec++;
        if ({done, error, load, busy, sck, hack_rst} !== 6'b100000 || words_loaded !== CW'(n)) begin
            n_err++;
            $display("FAIL %s_end got flags=%b wl=%0d want 100000 wl=%0d", name,
                     {done, error, load, busy, sck, hack_rst}, words_loaded, n);
        end
        n_vec++;
        if (got_m.size() != n || got_l.size() != n) begin
            n_err++;
            $display("FAIL %s_word_count got %0d/%0d want %0d", name, got_m.size(), got_l.size(), n);
        end
        for (int i = 0; i < n && i < got_m.size() && i < got_l.size(); i++) begin
            n_vec++;
            if (got_m[i] !== ref_word(i, 1'b1)) begin
                n_err++;
                $display("FAIL %s_msb_word%0d got %h want %h", name, i, got_m[i], ref_word(i, 1'b1));
            end
            n_vec++;
            if (got_l[i] !== ref_word(i, 1'b0)) begin
                n_err++;
                $display("FAIL %s_lsb_word%0d got %h want %h", name, i, got_l[i], ref_word(i, 1'b0));
            end
        end
    endtask

    task automatic test_basic();
        bytes_q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        run_checked("basic", 2, 0);
        n_vec++;
        if (got_m.size() > 1 && (got_m[0] !== 16'h1234 || got_m[1] !== 16'hABCD || got_l[0] !== 16'h3412)) begin
            n_err++;
            $display("FAIL basic_literal got %h %h %h want 1234 abcd 3412", got_m[0], got_m[1], got_l[0]);
        end
    endtask

    task automatic test_gaps();
        bytes_q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        run_checked("gaps", 2, 5);
    endtask

    task automatic test_timeout();
        int k;
        bytes_q = '{8'h5A, 8'hC3};
        ack_stuck = 1'b1;
        start_session(1);
        feed_range(0, 1, 0);
        k = 0;
        while (!sck && k < 20) begin
            tick();
            k++;
        end
        repeat (15) tick();
        n_vec++;
        if (error !== 1'b0 || sck !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_early got error=%b sck=%b want 0/1", error, sck);
        end
        tick();
        n_vec++;
        if ({error, load, sck, busy, done, hack_rst} !== 6'b100001 || words_loaded !== 16'd0) begin
            n_err++;
            $display("FAIL timeout_error got %b wl=%0d want 100001 wl=0", {error, load, sck, busy, done, hack_rst}, words_loaded);
        end
        ack_stuck = 1'b0;
        repeat (4) tick();
        start_session(1);
        n_vec++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_restart got error=%b busy=%b want 0/1", error, busy);
        end
        feed_range(0, 1, 1);
        wait_end(200);
        n_vec++;
        if (done !== 1'b1 || got_m.size() != 1 || got_m[0] !== 16'h5AC3) begin
            n_err++;
            $display("FAIL timeout_recover got done=%b words=%0d want done=1 word 5ac3", done, got_m.size());
        end
    endtask

    task automatic test_reset_mid();
        bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        start_session(2);
        feed_range(0, 2, 0);
        reset = 1'b1;
        tick();
        n_vec++;
        if ({s_ready, load, sck, busy, done, error, hack_rst} !== 7'b0000001 ||
            data !== 16'h0000 || words_loaded !== 16'd0) begin
            n_err++;
            $display("FAIL reset_mid got %b data=%h wl=%0d want 0000001/0/0",
                     {s_ready, load, sck, busy, done, error, hack_rst}, data, words_loaded);
        end
        tick();
        reset = 1'b0;
        repeat (5) tick();
        for (int i = 0; i < 4; i++) bytes_q[i] = 8'($urandom);
        run_checked("after_reset", 2, 2);
    endtask

    task automatic test_back_to_back();
        int n;
        for (int s = 0; s < 4; s++) begin
            n = $urandom_range(4, 1);
            bytes_q.delete();
            for (int i = 0; i < n*BPW; i++) bytes_q.push_back(8'($urandom));
            run_checked("b2b", n, 2);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        word_count = '0;
        s_valid = 1'b0;
        s_data = 8'h00;
        ack_stuck = 1'b0;
        test_reset();
        test_zero_count();
        test_basic();
        test_gaps();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
